mem_req_issuer: RTL and testbench
=================================

# mem_req_issuer

Issues memory requests from the CPU MEM stage into the RAM1/UART memory controller, which sits directly downstream. It latches each load/store, advances the 32-bit transaction token `mem_act` so the controller sees a new request, and stalls the pipeline until the controller reports completion for that token. Reads of the UART status address are answered locally from queue pointers and `tbre`, with no controller round-trip. A watchdog releases the pipeline if the controller never completes.

## Interface
- `UART_STAT_ADDR`, default 16'hBF01: locally answered status address.
- `TIMEOUT_W`, default 20: watchdog counter width. Timeout fires at 2^TIMEOUT_W − 1 wait cycles.
- `clk` in 1: system clock; all state changes on the posedge.
- `rst` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: the MEM stage holds a load or store.
- `req_wr` in 1: 1 = store, 0 = load.
- `req_addr` in 16: request address.
- `req_wdata` in 16: store data.
- `stall` out 1: freeze the pipeline.
- `rdata` out 16: load result, registered.
- `rdata_valid` out 1: one-cycle pulse when `rdata` is updated.
- `timeout_err` out 1: sticky flag; cleared only by reset.
- `need_to_work` out 1: request present to the controller.
- `mem_rd` out 1: read command to the controller.
- `mem_wr` out 1: write command to the controller.
- `mem_addr` out 16: address to the controller.
- `mem_value` out 16: write data to the controller.
- `mem_act` out 32: transaction token.
- `work_done` in 1: controller done. Valid only when its token matches `mem_act`.
- `result` in 16: controller read data.
- `q_front` in QueueSize: receive-queue front pointer.
- `q_tail` in QueueSize: receive-queue tail pointer.
- `tbre` in 1: UART transmitter buffer empty.

## Operation
- States:
  - IDLE: no request in flight.
  - ISSUE: token just advanced; controller not yet observed.
  - WAIT: waiting for `work_done`.
  - DONE: one-cycle completion state.
- IDLE, `req_valid`=1, `req_addr`≠`UART_STAT_ADDR`:
  - Latch `req_wr`, `req_addr` and `req_wdata` into `mem_wr`, `mem_addr` and `mem_value`.
  - Set `mem_rd` = !`req_wr` and `need_to_work`=1.
  - Set `mem_act` ← `mem_act`+1, wrapping modulo 2^32.
  - Go to ISSUE.
- IDLE, `req_valid`=1, `req_addr`=`UART_STAT_ADDR`, load:
  - `rdata` ← {14'b0, (`q_front`≠`q_tail`), `tbre`}.
  - Go to DONE. The token is unchanged.
- IDLE, `req_valid`=1, `req_addr`=`UART_STAT_ADDR`, store: the write is discarded. Go to DONE; `rdata` is unchanged.
- ISSUE → WAIT unconditionally. `work_done` is ignored in ISSUE.
- WAIT, `work_done`=1:
  - `rdata` ← `result` if the request was a load; unchanged if it was a store.
  - `need_to_work`, `mem_rd` and `mem_wr` ← 0.
  - Go to DONE.
- WAIT, watchdog reaches all-ones:
  - `timeout_err` ← 1 and `rdata` ← 16'h0000.
  - Drop `need_to_work`, `mem_rd` and `mem_wr`.
  - Go to DONE.
- DONE: `rdata_valid`=1 for this cycle only. Go to IDLE. `req_valid` is not sampled in DONE.
- `mem_addr`, `mem_value` and `mem_act` hold stable from ISSUE through DONE. They change only on acceptance in IDLE.
- `stall` = (IDLE & `req_valid`) | ISSUE | WAIT. It is combinational. In DONE, `stall`=0 so the pipeline advances past the completed request.
- Watchdog counter clears on entry to ISSUE and increments each cycle in WAIT.

## Timing
- Reset values:
  - State IDLE.
  - `mem_act`=0, `rdata`=0.
  - `rdata_valid`, `need_to_work`, `mem_rd`, `mem_wr` = 0.
  - `mem_addr`=0, `mem_value`=0.
  - `timeout_err`=0, watchdog=0.
- Reset mid-operation:
  - Returns to IDLE and zeroes `mem_act`.
  - The controller may still hold an old local token.
  - The first post-reset request produces token 1. This differs from any token ≥2 left in the controller; token 1 is accepted as a known corner case.
- Local status read: accept at cycle N, DONE at N+1, `stall` low at N+1. Latency is 1.
- Controller access:
  - Accept at N, ISSUE at N+1, WAIT from N+2.
  - `work_done` sampled high at cycle M (M ≥ N+2) gives DONE at M+1.
  - `rdata` is valid at M+1.
- Back-to-back requests: the next acceptance is no earlier than DONE+1. Consecutive tokens therefore always differ.
- Token wrap: 32'hFFFFFFFF+1 → 0. Treated as an ordinary token.

## Test plan
- Load 16'h1234 from address 16'h4000, controller returns 16'hBEEF 5 cycles after ISSUE:
  - `mem_rd`=1 and `mem_act`=1.
  - `stall` stays high until DONE.
  - `rdata`=16'hBEEF with a single `rdata_valid` pulse.
- Store 16'h00A5 to 16'hBF00:
  - `mem_wr`=1, `mem_value`=16'h00A5, `mem_act`=1.
  - `rdata` unchanged and `rdata_valid` pulses.
- Status read with `q_front`=3, `q_tail`=4, `tbre`=1:
  - `rdata`=16'h0003 one cycle after acceptance.
  - `mem_act` unchanged and `need_to_work`=0 throughout.
- Stale `work_done`=1 held high through ISSUE, with the real completion 3 cycles later:
  - No early completion.
  - DONE occurs only after the WAIT-state sample.
- Two back-to-back loads: tokens 1 then 2, and each `rdata_valid` returns that request's `result`.
- Controller never asserts `work_done`, with `TIMEOUT_W`=4:
  - DONE after 15 WAIT cycles.
  - `rdata`=0 and `timeout_err`=1 and stays high.
  - Async `rst` low mid-WAIT forces all outputs to their reset values immediately.

Source files
------------

// File: rtl/mem_req_issuer.sv
`default_nettype none
// ============================================================================
// Module   : mem_req_issuer
// Brief    : MEM-stage request issuer for the RAM1/UART controller. It uses a
//            token handshake, answers UART status reads locally, and has a
//            watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module mem_req_issuer #(
   parameter logic [15:0] UART_STAT_ADDR = 16'hBF01,
   parameter int          TIMEOUT_W      = 20,
   parameter int          QUEUE_SIZE     = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   input  logic                  req_wr,
   input  logic [15:0]           req_addr,
   input  logic [15:0]           req_wdata,
   output logic                  stall,
   output logic [15:0]           rdata,
   output logic                  rdata_valid,
   output logic                  timeout_err,
   output logic                  need_to_work,
   output logic                  mem_rd,
   output logic                  mem_wr,
   output logic [15:0]           mem_addr,
   output logic [15:0]           mem_value,
   output logic [31:0]           mem_act,
   input  logic                  work_done,
   input  logic [15:0]           result,
   input  logic [QUEUE_SIZE-1:0] q_front,
   input  logic [QUEUE_SIZE-1:0] q_tail,
   input  logic                  tbre
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // The watchdog fires on the WAIT cycle whose increment reaches all-ones.
   localparam logic [TIMEOUT_W-1:0] c_wdog_fire = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
   localparam logic [TIMEOUT_W-1:0] c_wdog_one  = {{(TIMEOUT_W-1){1'b0}}, 1'b1};

   state_t               r_state;
   logic [TIMEOUT_W-1:0] r_wdog;
   logic                 w_is_stat;
   logic [15:0]          w_stat_word;

   assign w_is_stat   = (req_addr == UART_STAT_ADDR);
   assign w_stat_word = {14'b0, (q_front != q_tail), tbre};

   assign stall = ((r_state == ST_IDLE) && req_valid) ||
                  (r_state == ST_ISSUE) || (r_state == ST_WAIT);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= ST_IDLE;
         r_wdog       <= '0;
         rdata        <= 16'h0000;
         rdata_valid  <= 1'b0;
         timeout_err  <= 1'b0;
         need_to_work <= 1'b0;
         mem_rd       <= 1'b0;
         mem_wr       <= 1'b0;
         mem_addr     <= 16'h0000;
         mem_value    <= 16'h0000;
         mem_act      <= 32'h0000_0000;
      end else begin
         rdata_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (req_valid) begin
                  if (w_is_stat) begin
                     // Status writes are dropped; status reads never reach the controller.
                     if (!req_wr) begin
                        rdata <= w_stat_word;
                     end
                     rdata_valid <= 1'b1;
                     r_state     <= ST_DONE;
                  end else begin
                     mem_wr       <= req_wr;
                     mem_rd       <= !req_wr;
                     mem_addr     <= req_addr;
                     mem_value    <= req_wdata;
                     need_to_work <= 1'b1;
                     mem_act      <= mem_act + 32'd1;
                     r_wdog       <= '0;
                     r_state      <= ST_ISSUE;
                  end
               end
            end
            // work_done may still reflect the previous token here, so ignore it.
            ST_ISSUE: begin
               r_state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (work_done) begin
                  if (mem_rd) begin
                     rdata <= result;
                  end
                  need_to_work <= 1'b0;
                  mem_rd       <= 1'b0;
                  mem_wr       <= 1'b0;
                  rdata_valid  <= 1'b1;
                  r_state      <= ST_DONE;
               end else if (r_wdog == c_wdog_fire) begin
                  timeout_err  <= 1'b1;
                  rdata        <= 16'h0000;
                  need_to_work <= 1'b0;
                  mem_rd       <= 1'b0;
                  mem_wr       <= 1'b0;
                  rdata_valid  <= 1'b1;
                  r_wdog       <= r_wdog + c_wdog_one;
                  r_state      <= ST_DONE;
               end else begin
                  r_wdog <= r_wdog + c_wdog_one;
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_req_issuer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_req_issuer
// Brief    : Directed self-checking bench for mem_req_issuer (TIMEOUT_W = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_req_issuer;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_wr;
   logic [15:0] req_addr;
   logic [15:0] req_wdata;
   logic        stall;
   logic [15:0] rdata;
   logic        rdata_valid;
   logic        timeout_err;
   logic        need_to_work;
   logic        mem_rd;
   logic        mem_wr;
   logic [15:0] mem_addr;
   logic [15:0] mem_value;
   logic [31:0] mem_act;
   logic        work_done;
   logic [15:0] result;
   logic [3:0]  q_front;
   logic [3:0]  q_tail;
   logic        tbre;

   int n_pass;
   int n_total;

   mem_req_issuer #(
      .UART_STAT_ADDR (16'hBF01),
      .TIMEOUT_W      (4),
      .QUEUE_SIZE     (4)
   ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_wr       (req_wr),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .stall        (stall),
      .rdata        (rdata),
      .rdata_valid  (rdata_valid),
      .timeout_err  (timeout_err),
      .need_to_work (need_to_work),
      .mem_rd       (mem_rd),
      .mem_wr       (mem_wr),
      .mem_addr     (mem_addr),
      .mem_value    (mem_value),
      .mem_act      (mem_act),
      .work_done    (work_done),
      .result       (result),
      .q_front      (q_front),
      .q_tail       (q_tail),
      .tbre         (tbre)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      step();
      step();
      rst = 1'b1;
   endtask

   task automatic check_idle_outputs(input string tag, input logic [31:0] exp_act);
      check_eq({tag, "_need"},  {31'b0, need_to_work}, 32'd0);
      check_eq({tag, "_rd"},    {31'b0, mem_rd},       32'd0);
      check_eq({tag, "_wr"},    {31'b0, mem_wr},       32'd0);
      check_eq({tag, "_act"},   mem_act,               exp_act);
   endtask

   // Controller access: accept, ISSUE, lat WAIT cycles without done, then done.
   task automatic do_access(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                            input logic [15:0] res, input int lat,
                            input logic [31:0] exp_tok, input logic [15:0] exp_rdata);
      req_valid = 1'b1;
      req_wr    = wr;
      req_addr  = addr;
      req_wdata = wdata;
      #1;
      check_eq("stall_req", {31'b0, stall}, 32'd1);
      step();
      req_valid = 1'b0;
      #1;
      check_eq("acc_act",   mem_act,                exp_tok);
      check_eq("acc_rd",    {31'b0, mem_rd},        {31'b0, !wr});
      check_eq("acc_wr",    {31'b0, mem_wr},        {31'b0, wr});
      check_eq("acc_need",  {31'b0, need_to_work},  32'd1);
      check_eq("acc_addr",  {16'b0, mem_addr},      {16'b0, addr});
      check_eq("acc_value", {16'b0, mem_value},     {16'b0, wdata});
      check_eq("acc_stall", {31'b0, stall},         32'd1);
      step();
      for (int i = 0; i < lat; i++) begin
         check_eq("wait_stall", {31'b0, stall},       32'd1);
         check_eq("wait_valid", {31'b0, rdata_valid}, 32'd0);
         step();
      end
      work_done = 1'b1;
      result    = res;
      step();
      work_done = 1'b0;
      check_eq("done_rdata", {16'b0, rdata},       {16'b0, exp_rdata});
      check_eq("done_valid", {31'b0, rdata_valid}, 32'd1);
      check_eq("done_stall", {31'b0, stall},       32'd0);
      check_idle_outputs("done", exp_tok);
      check_eq("done_addr",  {16'b0, mem_addr},    {16'b0, addr});
      step();
      check_eq("post_valid", {31'b0, rdata_valid}, 32'd0);
   endtask

   initial begin
      n_pass    = 0;
      n_total   = 0;
      rst       = 1'b0;
      req_valid = 1'b0;
      req_wr    = 1'b0;
      req_addr  = 16'h0000;
      req_wdata = 16'h0000;
      work_done = 1'b0;
      result    = 16'h0000;
      q_front   = 4'd0;
      q_tail    = 4'd0;
      tbre      = 1'b0;

      // Reset state
      do_reset();
      check_eq("rst_rdata", {16'b0, rdata},       32'd0);
      check_eq("rst_valid", {31'b0, rdata_valid}, 32'd0);
      check_eq("rst_tmo",   {31'b0, timeout_err}, 32'd0);
      check_eq("rst_stall", {31'b0, stall},       32'd0);
      check_idle_outputs("rst", 32'd0);

      // Load from 0x4000, completion a few cycles after ISSUE
      do_access(1'b0, 16'h4000, 16'h1234, 16'hBEEF, 4, 32'd1, 16'hBEEF);

      // Local status read: front != tail and tbre give 0x0003, no token change
      do_reset();
      q_front   = 4'd3;
      q_tail    = 4'd4;
      tbre      = 1'b1;
      req_valid = 1'b1;
      req_wr    = 1'b0;
      req_addr  = 16'hBF01;
      #1;
      check_eq("stat_stall_req", {31'b0, stall}, 32'd1);
      check_eq("stat_need_acc",  {31'b0, need_to_work}, 32'd0);
      step();
      req_valid = 1'b0;
      #1;
      check_eq("stat_rdata", {16'b0, rdata},       32'h0003);
      check_eq("stat_valid", {31'b0, rdata_valid}, 32'd1);
      check_eq("stat_stall", {31'b0, stall},       32'd0);
      check_idle_outputs("stat", 32'd0);
      step();
      check_eq("stat_post_valid", {31'b0, rdata_valid}, 32'd0);
      check_eq("stat_post_need",  {31'b0, need_to_work}, 32'd0);

      // Status-address store is discarded locally; rdata keeps 0x0003
      req_valid = 1'b1;
      req_wr    = 1'b1;
      req_addr  = 16'hBF01;
      req_wdata = 16'h5A5A;
      step();
      req_valid = 1'b0;
      check_eq("stst_rdata", {16'b0, rdata},       32'h0003);
      check_eq("stst_valid", {31'b0, rdata_valid}, 32'd1);
      check_idle_outputs("stst", 32'd0);
      step();

      // Store 0x00A5 to 0xBF00 goes to the controller; rdata unchanged
      do_access(1'b1, 16'hBF00, 16'h00A5, 16'h7777, 1, 32'd1, 16'h0003);

      // Stale work_done held high through ISSUE must not complete early
      req_valid = 1'b1;
      req_wr    = 1'b0;
      req_addr  = 16'h4002;
      work_done = 1'b1;
      result    = 16'hDEAD;
      step();
      req_valid = 1'b0;
      check_eq("stale_act", mem_act, 32'd2);
      step();
      work_done = 1'b0;
      check_eq("stale_stall", {31'b0, stall},       32'd1);
      check_eq("stale_valid", {31'b0, rdata_valid}, 32'd0);
      check_eq("stale_rdata", {16'b0, rdata},       32'h0003);
      for (int i = 0; i < 2; i++) begin
         step();
         check_eq("stale_wait", {31'b0, stall}, 32'd1);
      end
      work_done = 1'b1;
      result    = 16'hCAFE;
      step();
      work_done = 1'b0;
      check_eq("stale_done_rdata", {16'b0, rdata},       32'hCAFE);
      check_eq("stale_done_valid", {31'b0, rdata_valid}, 32'd1);
      step();

      // Back-to-back loads after reset: tokens 1 then 2
      do_reset();
      do_access(1'b0, 16'h0010, 16'h0000, 16'h1111, 0, 32'd1, 16'h1111);
      do_access(1'b0, 16'h0020, 16'h0000, 16'h2222, 2, 32'd2, 16'h2222);

      // Watchdog: no work_done, DONE after 15 WAIT cycles, rdata forced to 0
      req_valid = 1'b1;
      req_wr    = 1'b0;
      req_addr  = 16'h5000;
      step();
      req_valid = 1'b0;
      check_eq("tmo_act", mem_act, 32'd3);
      step();
      for (int i = 0; i < 14; i++) begin
         step();
         check_eq("tmo_wait_stall", {31'b0, stall},       32'd1);
         check_eq("tmo_wait_err",   {31'b0, timeout_err}, 32'd0);
      end
      step();
      check_eq("tmo_rdata", {16'b0, rdata},       32'd0);
      check_eq("tmo_err",   {31'b0, timeout_err}, 32'd1);
      check_eq("tmo_valid", {31'b0, rdata_valid}, 32'd1);
      check_eq("tmo_stall", {31'b0, stall},       32'd0);
      check_idle_outputs("tmo", 32'd3);
      step();
      check_eq("tmo_sticky", {31'b0, timeout_err}, 32'd1);

      // Sticky flag survives a normal access
      do_access(1'b0, 16'h0030, 16'h0000, 16'h3333, 1, 32'd4, 16'h3333);
      check_eq("tmo_sticky2", {31'b0, timeout_err}, 32'd1);

      // Async reset mid-WAIT clears everything without a clock edge
      req_valid = 1'b1;
      req_wr    = 1'b1;
      req_addr  = 16'h0040;
      req_wdata = 16'h9999;
      step();
      req_valid = 1'b0;
      step();
      step();
      #2;
      rst = 1'b0;
      #1;
      check_eq("arst_stall", {31'b0, stall},       32'd0);
      check_eq("arst_tmo",   {31'b0, timeout_err}, 32'd0);
      check_eq("arst_rdata", {16'b0, rdata},       32'd0);
      check_eq("arst_addr",  {16'b0, mem_addr},    32'd0);
      check_eq("arst_value", {16'b0, mem_value},   32'd0);
      check_idle_outputs("arst", 32'd0);
      step();
      rst = 1'b1;

      // First request after reset gets token 1 again
      do_access(1'b0, 16'h0050, 16'h0000, 16'h4444, 0, 32'd1, 16'h4444);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

endmodule
`default_nettype wire
